// File: rtl/wb_pkg.sv
// wb_pkg: write-back encodings and a reusable sub-word load extension helper.
package wb_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {SEL_ALU = 2'b00, SEL_LOAD = 2'b01, SEL_LINK = 2'b10, SEL_RSVD = 2'b11} sel_e;
  typedef enum logic [1:0] {LD_BYTE = 2'b00, LD_HALF = 2'b01, LD_WORD = 2'b10, LD_WORD2 = 2'b11} ldsize_e;
  // raw must already have the selected lane shifted down to bit 0
  function automatic logic [MAX_W-1:0] ld_extend(input logic [MAX_W-1:0] raw, input logic [1:0] size, input logic sgn);
    return size == LD_BYTE ? {{(MAX_W-8){sgn & raw[7]}}, raw[7:0]} :
           size == LD_HALF ? {{(MAX_W-16){sgn & raw[15]}}, raw[15:0]} : raw;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half lane of a memory word and extends it.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] mem_i,
  input  logic [1:0]        size_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic              signed_i,
  output logic [DATA_W-1:0] data_o
);
  logic [OFF_W-1:0] lane;
  logic [MAX_W-1:0] wide;
  logic [MAX_W-1:0] ext;
  always_comb begin
    lane = size_i == LD_BYTE ? off_i : size_i == LD_HALF ? off_i & ~OFF_W'(1) : '0;
    wide = '0;
    wide[DATA_W-1:0] = mem_i >> {lane, 3'b000};
    ext = ld_extend(wide, size_i, signed_i);
    data_o = ext[DATA_W-1:0];
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: single registered write-back slot with handshake, bypass and retire counter.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16,
  localparam int OFF_W = $clog2(DATA_W/8)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_nop,
  input  logic              in_we,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_link,
  input  logic [1:0]        in_ldsize,
  input  logic [OFF_W-1:0]  in_ldoff,
  input  logic              in_ldsigned,
  input  logic              rf_busy,
  output logic              ctrl_writeEnable,
  output logic [REG_W-1:0]  ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);
  logic              occ_q, occ_d, we_q, we_d, nop_q, nop_d;
  logic [REG_W-1:0]  rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d, ld_data, res;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fire, accept;

  load_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .mem_i(in_mem), .size_i(in_ldsize), .off_i(in_ldoff), .signed_i(in_ldsigned), .data_o(ld_data)
  );

  always_comb begin
    fire = occ_q & ~rf_busy;
    in_ready = ~occ_q | ~rf_busy;
    accept = in_valid & in_ready;
    res = in_sel == SEL_LOAD ? ld_data : in_sel == SEL_LINK ? in_link : in_alu;
    occ_d = accept | (occ_q & ~fire);
    we_d = accept ? in_we & ~in_nop & (in_rd != '0) : we_q;
    nop_d = accept ? in_nop : nop_q;
    rd_d = accept ? in_rd : rd_q;
    data_d = accept ? res : data_q;
    cnt_d = fire & ~nop_q ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      occ_q <= 1'b0;
      we_q <= 1'b0;
      nop_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      occ_q <= occ_d;
      we_q <= we_d;
      nop_q <= nop_d;
      rd_q <= rd_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end

  assign ctrl_writeEnable = fire & we_q;
  assign ctrl_writeReg = occ_q ? rd_q : '0;
  assign data_writeReg = occ_q ? data_q : '0;
  assign fwd_valid = occ_q & we_q;
  assign fwd_rd = occ_q ? rd_q : '0;
  assign fwd_data = occ_q ? data_q : '0;
  assign retire_count = cnt_q;
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors for the write-back stage, CNT_W=4 to reach wrap quickly.
module tb_writeback_stage;
  logic clock = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_nop = 1'b0, in_we = 1'b0, in_ldsigned = 1'b0, rf_busy = 1'b0;
  logic [4:0] in_rd = '0, ctrl_writeReg, fwd_rd;
  logic [1:0] in_sel = '0, in_ldsize = '0, in_ldoff = '0;
  logic [31:0] in_alu = '0, in_mem = '0, in_link = '0, data_writeReg, fwd_data;
  logic ctrl_writeEnable, fwd_valid;
  logic [3:0] retire_count;
  int n_checks = 0, n_errors = 0;
  logic [3:0] exp_cnt = '0;
  logic [4:0] log_rd[$];
  logic [31:0] log_data[$];

  writeback_stage #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_nop(in_nop),
    .in_we(in_we), .in_rd(in_rd), .in_sel(in_sel), .in_alu(in_alu), .in_mem(in_mem),
    .in_link(in_link), .in_ldsize(in_ldsize), .in_ldoff(in_ldoff), .in_ldsigned(in_ldsigned),
    .rf_busy(rf_busy), .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) if (ctrl_writeEnable) begin
    log_rd.push_back(ctrl_writeReg);
    log_data.push_back(data_writeReg);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic we, input logic nop, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] sz,
                       input logic [1:0] off, input logic sgn);
    in_valid = 1'b1; in_rd = rd; in_we = we; in_nop = nop; in_sel = sel;
    in_alu = alu; in_mem = mem; in_link = 32'hCAFE_0010;
    in_ldsize = sz; in_ldoff = off; in_ldsigned = sgn;
  endtask

  // one isolated instruction: capture, inspect staged outputs, fire, inspect counter
  task automatic single(input string tag, input logic [4:0] rd, input logic we, input logic nop,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [1:0] sz, input logic [1:0] off, input logic sgn,
                        input logic exp_we, input logic [31:0] exp_data, input logic counts);
    issue(rd, we, nop, sel, alu, mem, sz, off, sgn);
    tick;
    in_valid = 1'b0;
    #1;
    check({tag, ".wen"}, {31'b0, ctrl_writeEnable}, {31'b0, exp_we});
    check({tag, ".fwdv"}, {31'b0, fwd_valid}, {31'b0, exp_we});
    check({tag, ".wreg"}, {27'b0, ctrl_writeReg}, {27'b0, rd});
    check({tag, ".data"}, data_writeReg, exp_data);
    tick;
    if (counts) exp_cnt = exp_cnt + 4'd1;
    check({tag, ".cnt"}, {28'b0, retire_count}, {28'b0, exp_cnt});
  endtask

  initial begin
    tick; tick;
    reset = 1'b0;
    #1;
    check("rst.wen", {31'b0, ctrl_writeEnable}, 32'd0);
    check("rst.wreg", {27'b0, ctrl_writeReg}, 32'd0);
    check("rst.data", data_writeReg, 32'd0);
    check("rst.fwdv", {31'b0, fwd_valid}, 32'd0);
    check("rst.fwdrd", {27'b0, fwd_rd}, 32'd0);
    check("rst.fwddata", fwd_data, 32'd0);
    check("rst.cnt", {28'b0, retire_count}, 32'd0);
    check("rst.ready", {31'b0, in_ready}, 32'd1);

    single("alu", 5'd3, 1, 0, 2'b00, 32'h1234_5678, 32'h0, 2'b00, 2'd0, 0, 1, 32'h1234_5678, 1);
    single("lb_s3", 5'd4, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b00, 2'd3, 1, 1, 32'hFFFF_FF80, 1);
    single("lbu_3", 5'd4, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b00, 2'd3, 0, 1, 32'h0000_0080, 1);
    single("lh_s2", 5'd5, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b01, 2'd2, 1, 1, 32'hFFFF_80FF, 1);
    single("lh_s3", 5'd5, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b01, 2'd3, 1, 1, 32'hFFFF_80FF, 1);
    single("lh_s0", 5'd5, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b01, 2'd0, 1, 1, 32'h0000_7F01, 1);
    single("lb_s1", 5'd6, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b00, 2'd1, 1, 1, 32'h0000_007F, 1);
    single("lbu_2", 5'd6, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b00, 2'd2, 0, 1, 32'h0000_00FF, 1);
    single("lw", 5'd7, 1, 0, 2'b01, 32'h0, 32'h80FF_7F01, 2'b11, 2'd1, 1, 1, 32'h80FF_7F01, 1);
    single("link", 5'd31, 1, 0, 2'b10, 32'h1, 32'h2, 2'b10, 2'd0, 0, 1, 32'hCAFE_0010, 1);
    single("rsvd", 5'd8, 1, 0, 2'b11, 32'hDEAD_BEEF, 32'h2, 2'b10, 2'd0, 0, 1, 32'hDEAD_BEEF, 1);
    single("r0", 5'd0, 1, 0, 2'b00, 32'h5, 32'h0, 2'b10, 2'd0, 0, 0, 32'h5, 1);
    single("we0", 5'd9, 0, 0, 2'b00, 32'h6, 32'h0, 2'b10, 2'd0, 0, 0, 32'h6, 1);
    single("nop", 5'd4, 1, 1, 2'b00, 32'h7, 32'h0, 2'b10, 2'd0, 0, 0, 32'h7, 0);

    // stream four writes, holding the second with rf_busy for three cycles
    log_rd.delete(); log_data.delete();
    issue(5'd10, 1, 0, 2'b00, 32'hA0, 32'h0, 2'b10, 2'd0, 0);
    tick;
    issue(5'd11, 1, 0, 2'b00, 32'hA1, 32'h0, 2'b10, 2'd0, 0);
    tick;
    issue(5'd12, 1, 0, 2'b00, 32'hA2, 32'h0, 2'b10, 2'd0, 0);
    rf_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold.ready", {31'b0, in_ready}, 32'd0);
      check("hold.fwdv", {31'b0, fwd_valid}, 32'd1);
      check("hold.wen", {31'b0, ctrl_writeEnable}, 32'd0);
      check("hold.wreg", {27'b0, ctrl_writeReg}, 32'd11);
      check("hold.data", data_writeReg, 32'hA1);
      tick;
    end
    rf_busy = 1'b0;
    #1;
    check("rel.ready", {31'b0, in_ready}, 32'd1);
    check("rel.wen", {31'b0, ctrl_writeEnable}, 32'd1);
    tick;
    issue(5'd13, 1, 0, 2'b00, 32'hA3, 32'h0, 2'b10, 2'd0, 0);
    tick;
    in_valid = 1'b0;
    tick; tick;
    check("strm.n", log_rd.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("strm.rd", i < log_rd.size() ? {27'b0, log_rd[i]} : 32'hFFFF_FFFF, 32'd10 + i);
      check("strm.data", i < log_data.size() ? log_data[i] : 32'hFFFF_FFFF, 32'hA0 + i);
    end
    exp_cnt = exp_cnt + 4'd4;
    check("strm.cnt", {28'b0, retire_count}, {28'b0, exp_cnt});

    // reset while an entry is held drops it
    issue(5'd9, 1, 0, 2'b00, 32'h55, 32'h0, 2'b10, 2'd0, 0);
    tick;
    in_valid = 1'b0;
    rf_busy = 1'b1;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    rf_busy = 1'b0;
    #1;
    exp_cnt = '0;
    check("mrst.wen", {31'b0, ctrl_writeEnable}, 32'd0);
    check("mrst.fwdv", {31'b0, fwd_valid}, 32'd0);
    check("mrst.data", data_writeReg, 32'd0);
    check("mrst.cnt", {28'b0, retire_count}, 32'd0);
    tick;
    check("mrst.nwr", log_rd.size(), 32'd4);
    check("mrst.cnt2", {28'b0, retire_count}, 32'd0);

    // 17 back-to-back retirements on a 4-bit counter
    issue(5'd1, 1, 0, 2'b00, 32'h1, 32'h0, 2'b10, 2'd0, 0);
    for (int i = 0; i < 17; i++) tick;
    in_valid = 1'b0;
    check("wrap.16", {28'b0, retire_count}, 32'd0);
    tick;
    check("wrap.17", {28'b0, retire_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
